// File: rtl/gfx256_pkg.sv
// -----------------------------------------------------------------------------
// gfx256_pkg
// Shared types and constants for the 256-bit graphics memory arbiter.
//   arb_state_e  : arbiter FSM encoding (also exported on the debug state port)
//   REQ_*        : requester slot assignment used by the graphics engines
//   idx_w()      : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package gfx256_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    localparam int REQ_RENDER = 0;
    localparam int REQ_READER = 1;
    localparam int REQ_CLEAR  = 2;

    // Index width, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gfx256_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// gfx256_mem_arbiter_if
// Wishbone master bus between the arbiter and the wbm interface block.
//   master modport : arbiter side (drives cyc/stb/we/adr/sel/dat, takes dat/ack)
//   slave  modport : memory side
// Handshake: a transfer is offered while m_cyc_o & m_stb_o are high and the
// address/data fields are stable; it completes in the cycle m_ack_i is high,
// and m_dat_i is valid only in that cycle.
// -----------------------------------------------------------------------------
interface gfx256_mem_arbiter_if #(
    parameter int MDW = 256
);
    logic             m_cyc_o;
    logic             m_stb_o;
    logic             m_we_o;
    logic [31:0]      m_adr_o;
    logic [MDW/8-1:0] m_sel_o;
    logic [MDW-1:0]   m_dat_o;
    logic [MDW-1:0]   m_dat_i;
    logic             m_ack_i;

    modport master (
        output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
        input  m_dat_i, m_ack_i
    );

    modport slave (
        input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o,
        output m_dat_i, m_ack_i
    );
endinterface

// File: rtl/gfx256_rr_pick.sv
// -----------------------------------------------------------------------------
// gfx256_rr_pick
// Combinational rotating-priority picker. The search starts just after the
// last granted requester and wraps, so the previous owner has lowest priority.
//   req_i    : request vector
//   last_i   : index of the last granted requester
//   gnt_oh_o : one-hot winner (zero when nothing is requested)
//   idx_o    : index of the winner
//   any_o    : at least one request present
// -----------------------------------------------------------------------------
module gfx256_rr_pick
    import gfx256_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int            sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_oh_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        sum      = 0;
        cand     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum = int'(last_i) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = IW'(sum);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                gnt_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfx256_mem_arbiter.sv
// -----------------------------------------------------------------------------
// gfx256_mem_arbiter
// Shares one 256-bit Wishbone master port between NREQ graphics requesters
// (renderer, texture/blit reader, clear engine). Round-robin, one transaction
// in flight; lock_i keeps the grant across a read-modify-write pair.
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-low reset
//   req_i/we_i/lock_i : per-requester request, write enable, hold-grant
//   adr_i/sel_i/dat_i : packed per-requester fields (requester k at slot k)
//   ack_o/err_o       : one-cycle completion / timeout pulses
//   gnt_o             : one-hot current owner
//   dat_o             : shared read data, updated on each normal ack
//   wbm               : Wishbone master bus (master modport)
//   state_o           : FSM state, for debug and checkers
//
// Requester handshake: raise req_i with fields valid; fields are captured in
// the cycle the request is granted. Hold req_i until ack_o, then drop it in
// the ack_o cycle unless a locked follow-up access is intended.
//
// Build option: define GFX_ARB_TIMEOUT_EN to add a bus watchdog that
// terminates an access with ack_o+err_o after TO_CYCLES un-acked cycles.
// -----------------------------------------------------------------------------
module gfx256_mem_arbiter
    import gfx256_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int MDW       = 256,
    parameter int TO_CYCLES = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ-1:0]       we_i,
    input  logic [NREQ-1:0]       lock_i,
    input  logic [NREQ*32-1:0]    adr_i,
    input  logic [NREQ*MDW/8-1:0] sel_i,
    input  logic [NREQ*MDW-1:0]   dat_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [NREQ-1:0]       err_o,
    output logic [NREQ-1:0]       gnt_o,
    output logic [MDW-1:0]        dat_o,
    gfx256_mem_arbiter_if.master  wbm,
    output arb_state_e            state_o
);

    localparam int IW = idx_w(NREQ);
    localparam int SW = MDW / 8;

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1) begin : g_param_check
        $error("gfx256_mem_arbiter: parameter out of range");
    end

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [MDW-1:0]  rdat_q, rdat_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [MDW-1:0]  wdat_q, wdat_d;

`ifdef GFX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] err_q, err_d;
`endif

    // A requester acked this cycle is still holding req_i high by design of
    // the handshake, so it is masked out to avoid a spurious re-grant.
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    assign eligible = req_i & ~ack_q;

    gfx256_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (eligible),
        .last_i   (last_q),
        .gnt_oh_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Fields are taken from the new winner in IDLE, from the owner in LOCKED.
    logic [IW-1:0]  src_idx;
    logic           we_pick;
    logic [31:0]    adr_pick;
    logic [SW-1:0]  sel_pick;
    logic [MDW-1:0] dat_pick;

    assign src_idx  = (state_q == ARB_IDLE) ? pick_idx : gidx_q;
    assign we_pick  = we_i[src_idx];
    assign adr_pick = adr_i[32*src_idx +: 32];
    assign sel_pick = sel_i[SW*src_idx +: SW];
    assign dat_pick = dat_i[MDW*src_idx +: MDW];

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdat_d  = rdat_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
`ifdef GFX_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gidx_d  = pick_idx;
                    gnt_d   = pick_oh;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = we_pick;
                    adr_d   = adr_pick;
                    sel_d   = sel_pick;
                    wdat_d  = dat_pick;
                    state_d = ARB_ACCESS;
`ifdef GFX_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_ACCESS: begin
                if (wbm.m_ack_i) begin
                    stb_d  = 1'b0;
                    ack_d  = gnt_q;
                    rdat_d = wbm.m_dat_i;
                    last_d = gidx_q;
                    if (lock_i[gidx_q]) begin
                        state_d = ARB_LOCKED;
                    end else begin
                        cyc_d   = 1'b0;
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end
`ifdef GFX_ARB_TIMEOUT_EN
                // Watchdog: abandon the access, lock is deliberately ignored.
                else if (cnt_q == CW'(TO_CYCLES - 1)) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ack_d   = gnt_q;
                    err_d   = gnt_q;
                    last_d  = gidx_q;
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ARB_LOCKED: begin
                // ack_q guards against the follow-up being the request that
                // was just acked (req_i is still high in the ack cycle).
                if (req_i[gidx_q] && !ack_q[gidx_q]) begin
                    stb_d   = 1'b1;
                    we_d    = we_pick;
                    adr_d   = adr_pick;
                    sel_d   = sel_pick;
                    wdat_d  = dat_pick;
                    state_d = ARB_ACCESS;
`ifdef GFX_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (!lock_i[gidx_q] && !req_i[gidx_q]) begin
                    cyc_d   = 1'b0;
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            gidx_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            rdat_q  <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
`ifdef GFX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
`ifdef GFX_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign gnt_o       = gnt_q;
    assign dat_o       = rdat_q;
    assign state_o     = state_q;
    assign wbm.m_cyc_o = cyc_q;
    assign wbm.m_stb_o = stb_q;
    assign wbm.m_we_o  = we_q;
    assign wbm.m_adr_o = adr_q;
    assign wbm.m_sel_o = sel_q;
    assign wbm.m_dat_o = wdat_q;

`ifdef GFX_ARB_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

endmodule

// File: tb/tb_gfx256_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gfx256_mem_arbiter
// Directed bench for gfx256_mem_arbiter: reset, single write, three-way
// contention, read data return, locked RMW, reset mid-access and (when
// GFX_ARB_TIMEOUT_EN is defined) the bus watchdog with TO_CYCLES=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_gfx256_mem_arbiter;
    import gfx256_pkg::*;

    localparam int NREQ      = 3;
    localparam int MDW       = 256;
    localparam int SW        = MDW / 8;
    localparam int TO_CYCLES = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic [NREQ-1:0]      req_i = '0;
    logic [NREQ-1:0]      we_i = '0;
    logic [NREQ-1:0]      lock_i = '0;
    logic [NREQ*32-1:0]   adr_i = '0;
    logic [NREQ*SW-1:0]   sel_i = '0;
    logic [NREQ*MDW-1:0]  dat_i = '0;
    logic [NREQ-1:0]      ack_o;
    logic [NREQ-1:0]      err_o;
    logic [NREQ-1:0]      gnt_o;
    logic [MDW-1:0]       dat_o;
    arb_state_e           state_o;

    gfx256_mem_arbiter_if #(.MDW(MDW)) wbm ();

    gfx256_mem_arbiter #(
        .NREQ      (NREQ),
        .MDW       (MDW),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .lock_i  (lock_i),
        .adr_i   (adr_i),
        .sel_i   (sel_i),
        .dat_i   (dat_i),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .gnt_o   (gnt_o),
        .dat_o   (dat_o),
        .wbm     (wbm.master),
        .state_o (state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fails  = 0;
    logic [1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [MDW-1:0] obs,
                            input logic [MDW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input int k, input logic we, input logic lock,
                             input logic [31:0] adr, input logic [MDW-1:0] dat);
        we_i[k]              = we;
        lock_i[k]            = lock;
        adr_i[32*k +: 32]    = adr;
        sel_i[SW*k +: SW]    = '1;
        dat_i[MDW*k +: MDW]  = dat;
        req_i[k]             = 1'b1;
    endtask

    task automatic drop_req(input int k);
        req_i[k]  = 1'b0;
        lock_i[k] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_i       = 1'b0;
        req_i       = '0;
        lock_i      = '0;
        we_i        = '0;
        wbm.m_ack_i = 1'b0;
        wbm.m_dat_i = '0;
        tick();
        tick();
        check_eq("rst_state", MDW'(state_o), MDW'(ARB_IDLE));
        check_eq("rst_cyc", MDW'(wbm.m_cyc_o), '0);
        check_eq("rst_gnt", MDW'(gnt_o), '0);
        check_eq("rst_ack", MDW'(ack_o), '0);
        rst_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [MDW-1:0] wpat;
    logic [MDW-1:0] rpat;

    initial begin
        wbm.m_ack_i = 1'b0;
        wbm.m_dat_i = '0;

        // Reset state.
        apply_reset();
        check_eq("rst_dat", dat_o, '0);
        check_eq("rst_stb", MDW'(wbm.m_stb_o), '0);
        check_eq("rst_err", MDW'(err_o), '0);

        // Single write by the renderer, ack after two strobe cycles.
        wpat = {8{32'h1111_2222}};
        drive_req(REQ_RENDER, 1'b1, 1'b0, 32'h0000_1000, wpat);
        tick();
        check_eq("wr_stb", MDW'(wbm.m_stb_o), MDW'(1));
        check_eq("wr_cyc", MDW'(wbm.m_cyc_o), MDW'(1));
        check_eq("wr_gnt", MDW'(gnt_o), MDW'(3'b001));
        check_eq("wr_adr", MDW'(wbm.m_adr_o), MDW'(32'h0000_1000));
        check_eq("wr_we", MDW'(wbm.m_we_o), MDW'(1));
        check_eq("wr_sel", MDW'(wbm.m_sel_o), MDW'(32'hFFFF_FFFF));
        check_eq("wr_dat", wbm.m_dat_o, wpat);
        tick();
        check_eq("wr_wait_ack", MDW'(ack_o), '0);
        wbm.m_ack_i = 1'b1;
        tick();
        check_eq("wr_ack", MDW'(ack_o), MDW'(3'b001));
        check_eq("wr_err", MDW'(err_o), '0);
        check_eq("wr_cyc_drop", MDW'(wbm.m_cyc_o), '0);
        check_eq("wr_gnt_drop", MDW'(gnt_o), '0);
        drop_req(REQ_RENDER);
        wbm.m_ack_i = 1'b0;
        tick();
        check_eq("wr_ack_pulse", MDW'(ack_o), '0);
        check_eq("wr_idle", MDW'(state_o), MDW'(ARB_IDLE));

        // Contention: all three request continuously, zero-wait memory.
        apply_reset();
        exp_q = {2'd0, 2'd1, 2'd2, 2'd0};
        drive_req(0, 1'b0, 1'b0, 32'h0000_0100, '0);
        drive_req(1, 1'b0, 1'b0, 32'h0000_0200, '0);
        drive_req(2, 1'b1, 1'b0, 32'h0000_0300, '0);
        wbm.m_ack_i = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick();
            if (ack_o != '0) begin
                check_eq("cont_order", MDW'(ack_o), MDW'(1) << exp_q.pop_front());
            end
        end
        check_eq("cont_done", MDW'(exp_q.size()), '0);
        req_i       = '0;
        wbm.m_ack_i = 1'b0;
        tick();
        tick();

        // Read by the texture reader; data returned and held.
        rpat = {32{8'hA5}};
        drive_req(REQ_READER, 1'b0, 1'b0, 32'h0000_2200, '0);
        tick();
        check_eq("rd_gnt", MDW'(gnt_o), MDW'(3'b010));
        check_eq("rd_we", MDW'(wbm.m_we_o), '0);
        check_eq("rd_adr", MDW'(wbm.m_adr_o), MDW'(32'h0000_2200));
        wbm.m_ack_i = 1'b1;
        wbm.m_dat_i = rpat;
        tick();
        check_eq("rd_ack", MDW'(ack_o), MDW'(3'b010));
        check_eq("rd_dat", dat_o, rpat);
        drop_req(REQ_READER);
        wbm.m_ack_i = 1'b0;
        wbm.m_dat_i = '0;
        tick();
        check_eq("rd_dat_hold", dat_o, rpat);
        check_eq("rd_ack_pulse", MDW'(ack_o), '0);

        // Locked RMW by the renderer while the clear engine waits.
        drive_req(REQ_RENDER, 1'b0, 1'b1, 32'h0000_2000, '0);
        tick();
        check_eq("lk_gnt0", MDW'(gnt_o), MDW'(3'b001));
        drive_req(REQ_CLEAR, 1'b1, 1'b0, 32'h0000_3000, {8{32'hC1EA_0002}});
        wbm.m_ack_i = 1'b1;
        wbm.m_dat_i = {8{32'h0BAD_F00D}};
        tick();
        check_eq("lk_rd_ack", MDW'(ack_o), MDW'(3'b001));
        check_eq("lk_rd_dat", dat_o, {8{32'h0BAD_F00D}});
        check_eq("lk_cyc_held", MDW'(wbm.m_cyc_o), MDW'(1));
        check_eq("lk_gnt_held", MDW'(gnt_o), MDW'(3'b001));
        check_eq("lk_state", MDW'(state_o), MDW'(ARB_LOCKED));
        wbm.m_ack_i = 1'b0;
        drive_req(REQ_RENDER, 1'b1, 1'b0, 32'h0000_2000, {8{32'h0BAD_F00E}});
        tick();
        check_eq("lk_wait_gnt", MDW'(gnt_o), MDW'(3'b001));
        check_eq("lk_wait_stb", MDW'(wbm.m_stb_o), '0);
        tick();
        check_eq("lk_wr_stb", MDW'(wbm.m_stb_o), MDW'(1));
        check_eq("lk_wr_we", MDW'(wbm.m_we_o), MDW'(1));
        check_eq("lk_wr_dat", wbm.m_dat_o, {8{32'h0BAD_F00E}});
        check_eq("lk_wr_gnt", MDW'(gnt_o), MDW'(3'b001));
        wbm.m_ack_i = 1'b1;
        tick();
        check_eq("lk_wr_ack", MDW'(ack_o), MDW'(3'b001));
        check_eq("lk_release", MDW'(gnt_o), '0);
        drop_req(REQ_RENDER);
        wbm.m_ack_i = 1'b0;
        tick();
        check_eq("lk_next_gnt", MDW'(gnt_o), MDW'(3'b100));
        check_eq("lk_next_adr", MDW'(wbm.m_adr_o), MDW'(32'h0000_3000));
        wbm.m_ack_i = 1'b1;
        tick();
        check_eq("lk_next_ack", MDW'(ack_o), MDW'(3'b100));
        drop_req(REQ_CLEAR);
        wbm.m_ack_i = 1'b0;
        tick();

        // Reset in the middle of an access.
        drive_req(REQ_RENDER, 1'b1, 1'b0, 32'h0000_6000, {8{32'h6666_6666}});
        tick();
        check_eq("rm_stb", MDW'(wbm.m_stb_o), MDW'(1));
        rst_i       = 1'b0;
        wbm.m_ack_i = 1'b1;
        tick();
        check_eq("rm_ack", MDW'(ack_o), '0);
        check_eq("rm_cyc", MDW'(wbm.m_cyc_o), '0);
        check_eq("rm_stb_drop", MDW'(wbm.m_stb_o), '0);
        check_eq("rm_gnt", MDW'(gnt_o), '0);
        check_eq("rm_dat", dat_o, '0);
        check_eq("rm_state", MDW'(state_o), MDW'(ARB_IDLE));
        rst_i       = 1'b1;
        drop_req(REQ_RENDER);
        wbm.m_ack_i = 1'b0;
        tick();
        check_eq("rm_no_ack", MDW'(ack_o), '0);

`ifdef GFX_ARB_TIMEOUT_EN
        // Watchdog: memory never acks.
        apply_reset();
        drive_req(REQ_RENDER, 1'b1, 1'b0, 32'h0000_4000, '0);
        drive_req(REQ_READER, 1'b0, 1'b0, 32'h0000_5000, '0);
        tick();
        check_eq("to_gnt", MDW'(gnt_o), MDW'(3'b001));
        repeat (TO_CYCLES - 1) tick();
        check_eq("to_wait_ack", MDW'(ack_o), '0);
        check_eq("to_wait_cyc", MDW'(wbm.m_cyc_o), MDW'(1));
        tick();
        check_eq("to_ack", MDW'(ack_o), MDW'(3'b001));
        check_eq("to_err", MDW'(err_o), MDW'(3'b001));
        check_eq("to_cyc", MDW'(wbm.m_cyc_o), '0);
        drop_req(REQ_RENDER);
        tick();
        check_eq("to_next_gnt", MDW'(gnt_o), MDW'(3'b010));
        check_eq("to_err_pulse", MDW'(err_o), '0);
        wbm.m_ack_i = 1'b1;
        tick();
        check_eq("to_next_ack", MDW'(ack_o), MDW'(3'b010));
        check_eq("to_next_err", MDW'(err_o), '0);
        drop_req(REQ_READER);
        wbm.m_ack_i = 1'b0;
        tick();
`endif

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
